// File: rtl/display_pkg.sv
// Shared display-link types: digit width, receiver state encoding, BCD digit helpers.
// The DISPLAY_IN_BCD_CHECK_EN macro enables the digit check in display_in.
package display_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVERRUN
  } state_t;

  // A nibble above 9 is not a legal BCD digit
  function automatic logic bcd_digit_invalid(input bcd_digit_t d);
    return (d > bcd_digit_t'(9));
  endfunction

endpackage

// File: rtl/display_in.sv
// Serial-to-parallel receiver for the display link: rebuilds the packed BCD word
// from data_in/sending_data, pulses frame_valid on a good frame, frame_err on a
// short or overlong one.
// Optional: define DISPLAY_IN_BCD_CHECK_EN to add the per-digit nibble_err output.
module display_in
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          data_in,
  input  logic                          sending_data,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
  output logic                          frame_valid,
  output logic                          frame_err,
  output logic                          busy
`ifdef DISPLAY_IN_BCD_CHECK_EN
  ,
  output logic [NUM_DIGITS-1:0]         nibble_err
`endif
);

  localparam int unsigned FRAME_BITS = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_ovr_err;
  logic                  w_ovr_err_nxt;
  logic                  w_commit;
  logic                  w_err;
  logic                  w_cnt_full;

  assign w_cnt_full = (r_cnt == CNT_W'(FRAME_BITS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shift/count update and frame outcome decode
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_ovr_err_nxt = r_ovr_err;
    w_commit      = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      IDLE: begin
        if (sending_data) begin
          if (enable) begin
            w_shift_nxt = {r_shift[FRAME_BITS-2:0], data_in};
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = SHIFT;
          end else begin
            // Strobe already running without permission: swallow it silently
            w_ovr_err_nxt = 1'b0;
            w_state_nxt   = OVERRUN;
          end
        end
      end
      SHIFT: begin
        if (sending_data) begin
          if (!w_cnt_full) begin
            w_shift_nxt = {r_shift[FRAME_BITS-2:0], data_in};
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end else begin
            w_ovr_err_nxt = 1'b1;
            w_state_nxt   = OVERRUN;
          end
        end else begin
          w_commit    = w_cnt_full;
          w_err       = !w_cnt_full;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      OVERRUN: begin
        if (!sending_data) begin
          w_err         = r_ovr_err;
          w_ovr_err_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef DISPLAY_IN_BCD_CHECK_EN
  logic [NUM_DIGITS-1:0] w_nibble_bad;

  // Per-digit legality of the word about to be committed
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign w_nibble_bad[g] = bcd_digit_invalid(r_shift[g*DIGIT_W +: DIGIT_W]);
  end

  // Digit flags are captured together with bcd_out
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble_err <= '0;
    end else if (w_commit) begin
      nibble_err <= w_nibble_bad;
    end
  end
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_ovr_err   <= 1'b0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovr_err   <= w_ovr_err_nxt;
      frame_valid <= w_commit;
      frame_err   <= w_err;
      busy        <= (w_state_nxt != IDLE);
      if (w_commit) begin
        bcd_out <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_display_in.sv
// Directed bench for display_in (NUM_DIGITS = 4): good, short, overlong,
// back-to-back, reset-interrupted and unpermitted frames.
module tb_display_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        data_in;
  logic        sending_data;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;
`ifdef DISPLAY_IN_BCD_CHECK_EN
  logic [3:0]  nibble_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int nv, ne, nb_low;

  display_in #(.NUM_DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .data_in      (data_in),
    .sending_data (sending_data),
    .bcd_out      (bcd_out),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .busy         (busy)
`ifdef DISPLAY_IN_BCD_CHECK_EN
    ,
    .nibble_err   (nibble_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe high for len cycles (MSB first, zeros past bit 15), then one low cycle.
  // Pulses and busy are tallied while the strobe is high; returns just after the
  // edge that sees the strobe low.
  task automatic drive_frame(input logic [15:0] w, input int len, input int en_drop);
    nv = 0; ne = 0; nb_low = 0;
    for (int i = 0; i < len; i++) begin
      if (i == en_drop) enable = 1'b0;
      sending_data = 1'b1;
      data_in      = (i < 16) ? w[15-i] : 1'b0;
      @(negedge clk);
      if (frame_valid) nv++;
      if (frame_err)   ne++;
      if (!busy)       nb_low++;
    end
    sending_data = 1'b0;
    data_in      = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; data_in = 1'b0; sending_data = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_bcd",   32'(bcd_out),     32'h0);
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_err",   32'(frame_err),   32'h0);
    chk("rst_busy",  32'(busy),        32'h0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);

    // Good frame
    drive_frame(16'h2571, 16, -1);
    chk("f1_busy_low", 32'(nb_low), 32'd0);
    chk("f1_early_pulse", 32'(nv + ne), 32'd0);
    chk("f1_valid", 32'(frame_valid), 32'h1);
    chk("f1_err",   32'(frame_err),   32'h0);
    chk("f1_bcd",   32'(bcd_out),     32'h2571);
    chk("f1_busy_after", 32'(busy),   32'h0);
    @(negedge clk);
    chk("f1_valid_one", 32'(frame_valid), 32'h0);

    // Short frame, then a good one
    drive_frame(16'hFFFF, 10, -1);
    chk("short_err",   32'(frame_err),   32'h1);
    chk("short_valid", 32'(frame_valid), 32'h0);
    chk("short_bcd",   32'(bcd_out),     32'h2571);
    drive_frame(16'h0913, 16, -1);
    chk("f2_valid", 32'(frame_valid), 32'h1);
    chk("f2_err",   32'(frame_err),   32'h0);
    chk("f2_bcd",   32'(bcd_out),     32'h0913);

    // Overlong frame
    @(negedge clk);
    drive_frame(16'hABCD, 20, -1);
    chk("long_busy_low", 32'(nb_low), 32'd0);
    chk("long_pulses",   32'(nv + ne), 32'd0);
    chk("long_err",   32'(frame_err),   32'h1);
    chk("long_valid", 32'(frame_valid), 32'h0);
    chk("long_bcd",   32'(bcd_out),     32'h0913);
    chk("long_busy_after", 32'(busy),   32'h0);
    @(negedge clk);
    chk("long_err_one", 32'(frame_err), 32'h0);

    // Back-to-back frames with the minimum gap
    drive_frame(16'h1234, 16, -1);
    chk("b2b1_valid", 32'(frame_valid), 32'h1);
    chk("b2b1_bcd",   32'(bcd_out),     32'h1234);
    drive_frame(16'h5678, 16, -1);
    chk("b2b2_early_valid", 32'(nv), 32'd0);
    chk("b2b2_valid", 32'(frame_valid), 32'h1);
    chk("b2b2_bcd",   32'(bcd_out),     32'h5678);

    // Reset on bit 8 of a frame; the tail is seen as a short frame
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      sending_data = 1'b1;
      data_in      = 1'b1;
      rst          = (i == 8);
      @(negedge clk);
      if (i == 8) begin
        chk("mid_rst_bcd",   32'(bcd_out),     32'h0);
        chk("mid_rst_busy",  32'(busy),        32'h0);
        chk("mid_rst_valid", 32'(frame_valid), 32'h0);
        chk("mid_rst_err",   32'(frame_err),   32'h0);
      end
    end
    rst = 1'b0; sending_data = 1'b0; data_in = 1'b0;
    @(negedge clk);
    chk("tail_err",   32'(frame_err),   32'h1);
    chk("tail_valid", 32'(frame_valid), 32'h0);
    chk("tail_bcd",   32'(bcd_out),     32'h0);
    drive_frame(16'h4860, 16, -1);
    chk("post_rst_valid", 32'(frame_valid), 32'h1);
    chk("post_rst_bcd",   32'(bcd_out),     32'h4860);

    // Strobe without enable is swallowed silently
    @(negedge clk);
    enable = 1'b0;
    drive_frame(16'h1111, 16, -1);
    chk("noen_busy_low", 32'(nb_low), 32'd0);
    chk("noen_err",   32'(frame_err),   32'h0);
    chk("noen_valid", 32'(frame_valid), 32'h0);
    chk("noen_bcd",   32'(bcd_out),     32'h4860);

    // Enable dropping mid-frame does not disturb it
    @(negedge clk);
    enable = 1'b1;
    drive_frame(16'h3702, 16, 5);
    chk("endrop_valid", 32'(frame_valid), 32'h1);
    chk("endrop_bcd",   32'(bcd_out),     32'h3702);
    enable = 1'b1;

`ifdef DISPLAY_IN_BCD_CHECK_EN
    @(negedge clk);
    drive_frame(16'hA3F1, 16, -1);
    chk("nib_valid", 32'(frame_valid), 32'h1);
    chk("nib_bcd",   32'(bcd_out),     32'hA3F1);
    chk("nib_err",   32'(nibble_err),  32'hA);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_in.md
# display_in

Serial-to-parallel receiver for the display link: captures the one-bit-per-clock frame emitted by the display serializer (data line plus frame strobe) and reconstructs the packed BCD word. It sits on the display side of the link, or in a loopback bench. A one-cycle strobe reports each completed frame, and malformed frames (short or overlong strobe) are flagged. It is the receiving end of the serializer's `data_out`/`sending_data` pair.

## Interface
- `NUM_DIGITS`, default 4: BCD digits per frame; frame length is `4*NUM_DIGITS` bits.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: permits a new frame to start; sampled only in IDLE.
- `data_in` input, 1 bit: serial data, MSB first, one bit per clock while `sending_data` is high.
- `sending_data` input, 1 bit: frame strobe, high for exactly `4*NUM_DIGITS` consecutive cycles per frame.
- `bcd_out` output, `4*NUM_DIGITS` bits: last correctly received word; digit 0 is in bits [3:0].
- `frame_valid` output, 1 bit: one-cycle pulse when `bcd_out` has just been updated.
- `frame_err` output, 1 bit: one-cycle pulse on a short or overlong frame.
- `busy` output, 1 bit: high in SHIFT and OVERRUN.
- `nibble_err` output, `NUM_DIGITS` bits: present only with the macro; per-digit flag for nibble > 9.

## Operation
- Reset values:
  - `bcd_out` = 0, `frame_valid` = 0, `frame_err` = 0, `busy` = 0, `nibble_err` = 0.
  - State = IDLE, bit counter = 0, shift register = 0.
- **IDLE**
  - If `enable` and `sending_data` are high: shift in `data_in`, counter = 1, go to SHIFT.
  - If `sending_data` is high while `enable` is low: go to OVERRUN silently, so a partial frame is never captured.
- **SHIFT**, with `sending_data` high:
  - Counter < FRAME_BITS: shift left, inserting `data_in` at the LSB, counter++.
  - Counter == FRAME_BITS: go to OVERRUN.
- **SHIFT**, with `sending_data` low:
  - Counter == FRAME_BITS: `bcd_out` <= shift register, pulse `frame_valid`, go to IDLE.
  - Otherwise: pulse `frame_err`, keep `bcd_out`, go to IDLE.
- **OVERRUN**
  - Stay while `sending_data` is high.
  - On low: pulse `frame_err` if entered from SHIFT; no error if entered from IDLE with `enable` low. Then go to IDLE.
- `enable` deasserting mid-frame has no effect; the frame completes normally.
- Counter width is `$clog2(FRAME_BITS+1)` and it never wraps.
- `frame_valid` and `frame_err` are never high in the same cycle.

## Timing
- The first bit is sampled in the same cycle `sending_data` is first seen high.
- Last data bit sampled at edge N. `sending_data` is low at edge N+1. `bcd_out` and `frame_valid` are visible after edge N+1, which is 1 cycle after the strobe falls.
- Minimum inter-frame gap: 1 low cycle. A frame may start on the cycle immediately after the commit cycle.
- `rst` mid-frame discards the partial word and clears `bcd_out` on that edge.
- If `rst` and strobe edges coincide, `rst` wins.

## Configuration
- `DISPLAY_IN_BCD_CHECK_EN`
  - Defined: `nibble_err` port exists and is registered alongside the `bcd_out` commit. Each bit is set when its nibble > 9, and is held until the next commit or reset. `frame_valid` still pulses.
  - Undefined: port and check logic are absent; no digit validation is done.

## Structure
- Shared package `display_pkg` holds:
  - `DIGIT_W` = 4.
  - The state enum (IDLE, SHIFT, OVERRUN).
  - A `bcd_digit_t` typedef, shared with the serializer.
- No sub-module in the base block. With the macro, a combinational `bcd_nibble_check` (4-bit in, 1-bit out), instantiated `NUM_DIGITS` times, is natural.

## Test plan
- Loopback from the serializer, word 16'h2571 → `bcd_out` = 16'h2571 with one `frame_valid` pulse, one cycle after the strobe falls. `frame_err` stays 0.
- Strobe high 10 cycles → `frame_err` pulse; `bcd_out` keeps its prior value; next 16-bit frame 16'h0913 is received correctly.
- Strobe high 20 cycles → `busy` high throughout; one `frame_err` pulse after the strobe falls; no `frame_valid`.
- Two frames 16'h1234 then 16'h5678 with a 1-cycle gap → two `frame_valid` pulses with the correct values.
- `rst` pulsed at bit 8 of frame 16'h9999 → all outputs 0; the remainder of that strobe is treated as a short frame (`frame_err` pulse). The next full frame is received correctly.
- Macro defined, frame 16'hA3F1 → `nibble_err` = 4'b1010 and `frame_valid` pulses.
